// File: rtl/tag_range_dma_if.sv
// Command and tag-memory signal bundle for tag_range_dma.
// slave is the engine side; master is the requester/memory side.
interface tag_range_dma_if #(
  parameter int LEN_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic [31:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_tag;
  logic             busy;
  logic             done;
  logic             result_tainted;
  logic             tag_req;
  logic             tag_gnt;
  logic             tag_rvalid;
  logic [31:0]      tag_addr;
  logic             tag_we;
  logic [3:0]       tag_be;
  logic [3:0]       tag_wdata;
  logic [3:0]       tag_rdata;

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr,
    input  cmd_len, cmd_tag,
    input  tag_gnt, tag_rvalid, tag_rdata,
    output cmd_ready, busy, done,
    output result_tainted,
    output tag_req, tag_addr, tag_we,
    output tag_be, tag_wdata
  );

  modport master (
    output cmd_valid, cmd_op, cmd_addr,
    output cmd_len, cmd_tag,
    output tag_gnt, tag_rvalid, tag_rdata,
    input  cmd_ready, busy, done,
    input  result_tainted,
    input  tag_req, tag_addr, tag_we,
    input  tag_be, tag_wdata
  );
endinterface

// File: rtl/tag_range_dma.sv
// Tag range engine: FILL writes a tag bit over a byte range,
// CHECK ORs the tag bits of a range and stops at the first hit.
module tag_range_dma #(
  parameter int LEN_W = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  tag_range_dma_if.slave io
);
  typedef enum logic [1:0] {
    IDLE, REQ, RESP, DONE
  } state_e;

  state_e         state_q, state_d;
  logic [31:0]    word_q, word_d;
  logic [1:0]     off_q, off_d;
  logic [LEN_W:0] rem_q, rem_d;
  logic           acc_q, acc_d;
  logic           op_q, op_d;
  logic           tag_q, tag_d;

  logic [2:0] avail;
  logic [2:0] nb;
  logic [3:0] mask;
  logic [3:0] be;
  logic       active;

  // bytes covered in the current word
  always_comb begin
    avail = 3'd4 - {1'b0, off_q};
    if (rem_q < (LEN_W+1)'(avail)) begin
      nb = rem_q[2:0];
    end else begin
      nb = avail;
    end
    mask = 4'hF >> (3'd4 - nb);
    be   = mask << off_q;
  end

  assign active            = (state_q == REQ) || (state_q == RESP);
  assign io.cmd_ready      = (state_q == IDLE);
  assign io.busy           = (state_q != IDLE);
  assign io.done           = (state_q == DONE);
  assign io.result_tainted = (state_q == DONE) && acc_q;
  assign io.tag_req        = (state_q == REQ);
  assign io.tag_addr       = active ? word_q : 32'd0;
  assign io.tag_be         = active ? be : 4'd0;
  assign io.tag_we         = active && !op_q;
  assign io.tag_wdata      = (active && !op_q) ? {4{tag_q}} : 4'd0;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    off_d   = off_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    op_d    = op_q;
    tag_d   = tag_q;
    unique case (state_q)
      IDLE: begin
        if (io.cmd_valid) begin
          op_d   = io.cmd_op;
          tag_d  = io.cmd_tag;
          word_d = {io.cmd_addr[31:2], 2'b00};
          off_d  = io.cmd_addr[1:0];
          rem_d  = {1'b0, io.cmd_len};
          acc_d  = 1'b0;
          if (io.cmd_len == '0) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (io.tag_gnt) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (io.tag_rvalid) begin
          rem_d  = rem_q - (LEN_W+1)'(nb);
          off_d  = 2'd0;
          word_d = word_q + 32'd4;
          if (op_q && |(io.tag_rdata & be)) begin
            acc_d = 1'b1;
          end
          if (rem_d == '0 || acc_d) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= 32'd0;
      off_q   <= 2'd0;
      rem_q   <= '0;
      acc_q   <= 1'b0;
      op_q    <= 1'b0;
      tag_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      off_q   <= off_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      tag_q   <= tag_d;
    end
  end
endmodule

// File: doc/tag_range_dma.md
TAG_RANGE_DMA -- requirements
Module: tag_range_dma

Interface
REQ-001 Parameter LEN_W SHALL default to 16 and set the byte-count width of cmd_len.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  engine idle, command accepted when cmd_valid && cmd_ready.
REQ-006 cmd_op  input  1  0 = FILL (write tags), 1 = CHECK (read and OR tags).
REQ-007 cmd_addr  input  32  start byte address, any alignment.
REQ-008 cmd_len  input  LEN_W  byte count.
REQ-009 cmd_tag  input  1  tag bit written by FILL.
REQ-010 busy  output  1  high from acceptance until the end of the done cycle.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 result_tainted  output  1  CHECK result, valid while done=1; 0 for FILL.
REQ-013 tag_req  output  1  tag-memory request.
REQ-014 tag_gnt  input  1  tag-memory grant.
REQ-015 tag_rvalid  input  1  tag-memory response valid.
REQ-016 tag_addr  output  32  word-aligned byte address (bits [1:0] = 0).
REQ-017 tag_we  output  1  1 for FILL, 0 for CHECK.
REQ-018 tag_be  output  4  byte mask of the current word.
REQ-019 tag_wdata  output  4  {4{cmd_tag}} during FILL, 0 during CHECK.
REQ-020 tag_rdata  input  4  per-byte tag bits, sampled when tag_rvalid=1.

Function
REQ-021 FSM states SHALL be IDLE, REQ, RESP and DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-022 On acceptance with cmd_len != 0, the FSM SHALL go to REQ, with word = cmd_addr & ~3, offset = cmd_addr[1:0], rem = cmd_len (LEN_W+1 bits), and acc = 0.
REQ-023 On acceptance with cmd_len = 0, the FSM SHALL go to DONE and never assert tag_req.
REQ-024 Per word: nbytes = min(4-offset, rem); tag_be = ((1<<nbytes)-1)<<offset.
REQ-025 In REQ, tag_req SHALL be 1 and tag_addr/tag_we/tag_be/tag_wdata SHALL remain stable until the cycle tag_gnt=1; that cycle SHALL move the FSM to RESP.
REQ-026 In RESP, tag_req SHALL be 0, and at most one transaction SHALL ever be outstanding.
REQ-027 On tag_rvalid in RESP: rem -= nbytes; offset = 0; word += 4 (modulo 2^32, wrap permitted); CHECK SHALL set acc |= |(tag_rdata & tag_be).
REQ-028 After that response, the FSM SHALL go to DONE if rem = 0 or (CHECK and acc = 1), else to REQ.
REQ-029 A CHECK SHALL stop at the first tainted word, with no further requests.
REQ-030 In DONE, done SHALL be 1 and result_tainted = acc (CHECK) or 0 (FILL), followed by IDLE the next cycle.
REQ-031 tag_rvalid outside RESP SHALL be ignored; cmd_valid while busy SHALL be ignored.
REQ-032 The first tag_req SHALL assert the cycle after acceptance.
REQ-033 done SHALL assert the cycle after the final tag_rvalid.
REQ-034 Tag bits outside tag_be SHALL never affect result_tainted.

Reset
REQ-035 While rst_n=0, the engine SHALL hold IDLE with outputs: cmd_ready=1, busy=0, done=0, result_tainted=0, tag_req=0, tag_we=0, tag_be=0, tag_wdata=0, tag_addr=0.
REQ-036 Reset mid-operation SHALL abandon the command with no done pulse, and the engine SHALL accept a new command one cycle after rst_n rises.

Verification
REQ-037 FILL addr 0x102 len 7 tag 1, gnt=1 -> three writes: 0x100 be 1100, 0x104 be 1111, 0x108 be 0001, wdata F; done the cycle after the 3rd rvalid; result 0.
REQ-038 CHECK addr 0x200 len 12, rdata 0000 then 0100 -> 2 requests only, done with result_tainted=1.
REQ-039 CHECK addr 0x301 len 2 (be 0110), rdata 1001 -> single request, result_tainted=0.
REQ-040 tag_gnt low 5 cycles in REQ -> tag_req held high, tag_addr/be stable, no advance until gnt.
REQ-041 cmd_len 0 -> done 1 cycle after acceptance, result 0, tag_req never asserted.
REQ-042 rst_n pulsed low while in RESP -> tag_req=0, busy=0, no done; a new FILL after release completes normally.
